// File: rtl/mqnic_ptp_extts_pkg.sv
// Shared constants for the PTP external timestamp capture block:
// register offsets, register-block identity, ctrl/status bit positions,
// and the layout of one captured timestamp entry.
package mqnic_ptp_extts_pkg;

    // Register-block identity
    localparam logic [31:0] RB_TYPE    = 32'h0000C085;
    localparam logic [31:0] RB_VERSION = 32'h00000100;

    // Register offsets relative to the block base address
    localparam int REG_TYPE   = 'h00;
    localparam int REG_VER    = 'h04;
    localparam int REG_NEXT   = 'h08;
    localparam int REG_CTRL   = 'h0C;
    localparam int REG_STATUS = 'h10;
    localparam int REG_FNS    = 'h14;
    localparam int REG_NS     = 'h18;
    localparam int REG_SEC_LO = 'h1C;
    localparam int REG_SEC_HI = 'h20;
    localparam int RB_SPAN    = 'h24;

    // ctrl register bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RISE   = 1;
    localparam int CTRL_FALL   = 2;
    localparam int CTRL_FLUSH  = 3;
    localparam int CTRL_IRQ_EN = 8;

    // status register bits
    localparam int STS_NOT_EMPTY = 0;
    localparam int STS_OVERFLOW  = 1;
    localparam int STS_STEP      = 2;
    localparam int STS_COUNT_LSB = 8;

    localparam int NS_PER_SEC = 1000000000;
    localparam int ENTRY_W    = 97;

    // One FIFO entry: ToD step flag on top of the raw 96-bit ToD layout
    typedef struct packed {
        logic        step;
        logic [47:0] sec;
        logic [1:0]  rsvd;
        logic [29:0] ns;
        logic [15:0] fns;
    } ts_entry_t;

endpackage

// File: rtl/mqnic_ptp_extts_fifo.sv
// Synchronous FIFO holding captured timestamps, with single-cycle flush
// and an occupancy count. A write into a full FIFO is accepted only when
// a read retires the head in the same cycle.
module mqnic_ptp_extts_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 97,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty && !flush;
    assign do_wr   = wr_en && (!full || do_rd) && !flush;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mqnic_ptp_extts.sv
// PTP external event timestamper: synchronizes an asynchronous pin,
// detects qualified edges, stamps them with the ToD into a FIFO and
// exposes the FIFO through a small register block.
// Optional build macro MQNIC_PTP_EXTTS_LATENCY_COMP_EN removes the
// input path latency (SYNC_LATENCY_NS) from every captured timestamp.
//
// Register handshake: a request is accepted in the cycle its *_en is high
// when the address falls inside this block; *_ack pulses exactly one cycle
// later with read data valid alongside it. *_wait is never asserted.
// Requests outside the block are ignored (no ack, read data 0).
module mqnic_ptp_extts
    import mqnic_ptp_extts_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int SYNC_LATENCY_NS = 8,
    parameter int REG_ADDR_WIDTH  = 6,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_STRB_WIDTH  = 4,
    parameter int RB_BASE_ADDR    = 0,
    parameter int RB_NEXT_PTR     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0] reg_wr_data,
    input  logic [REG_STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                      reg_wr_en,
    output logic                      reg_wr_wait,
    output logic                      reg_wr_ack,
    input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0] reg_rd_data,
    output logic                      reg_rd_wait,
    output logic                      reg_rd_ack,
    input  logic [95:0]               ptp_ts_96,
    input  logic                      ptp_ts_step,
    input  logic                      ext_event,
    output logic                      irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [REG_ADDR_WIDTH-1:0] BASE     = REG_ADDR_WIDTH'(RB_BASE_ADDR);
    localparam logic [REG_ADDR_WIDTH-1:0] SPAN     = REG_ADDR_WIDTH'(RB_SPAN);
    localparam logic [REG_ADDR_WIDTH-1:0] A_TYPE   = REG_ADDR_WIDTH'(REG_TYPE);
    localparam logic [REG_ADDR_WIDTH-1:0] A_VER    = REG_ADDR_WIDTH'(REG_VER);
    localparam logic [REG_ADDR_WIDTH-1:0] A_NEXT   = REG_ADDR_WIDTH'(REG_NEXT);
    localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL   = REG_ADDR_WIDTH'(REG_CTRL);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS = REG_ADDR_WIDTH'(REG_STATUS);
    localparam logic [REG_ADDR_WIDTH-1:0] A_FNS    = REG_ADDR_WIDTH'(REG_FNS);
    localparam logic [REG_ADDR_WIDTH-1:0] A_NS     = REG_ADDR_WIDTH'(REG_NS);
    localparam logic [REG_ADDR_WIDTH-1:0] A_SEC_LO = REG_ADDR_WIDTH'(REG_SEC_LO);
    localparam logic [REG_ADDR_WIDTH-1:0] A_SEC_HI = REG_ADDR_WIDTH'(REG_SEC_HI);

    // Control / status state
    logic ctrl_en;
    logic ctrl_rise;
    logic ctrl_fall;
    logic ctrl_irq_en;
    logic overflow;

    // Pin synchronizer, edge history and post-reset arming
    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic [1:0] arm_cnt;
    logic       armed;
    logic       event_pulse;

    // Register decode
    logic [REG_ADDR_WIDTH-1:0] wr_off;
    logic [REG_ADDR_WIDTH-1:0] wr_word;
    logic                      wr_hit;
    logic [REG_ADDR_WIDTH-1:0] rd_off;
    logic [REG_ADDR_WIDTH-1:0] rd_word;
    logic                      rd_hit;
    logic [31:0]               rd_mux;

    // FIFO interface
    ts_entry_t     cap;
    ts_entry_t     fifo_q;
    ts_entry_t     head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count8;
    logic          flush_req;
    logic          sts_clear;
    logic          pop;
    logic          push;
    logic          ovf_set;

    assign reg_wr_wait = 1'b0;
    assign reg_rd_wait = 1'b0;

    assign wr_off  = reg_wr_addr - BASE;
    assign wr_hit  = reg_wr_en && (reg_wr_addr >= BASE) && (wr_off < SPAN);
    assign wr_word = {wr_off[REG_ADDR_WIDTH-1:2], 2'b00};
    assign rd_off  = reg_rd_addr - BASE;
    assign rd_hit  = reg_rd_en && (reg_rd_addr >= BASE) && (rd_off < SPAN);
    assign rd_word = {rd_off[REG_ADDR_WIDTH-1:2], 2'b00};

    assign flush_req = wr_hit && (wr_word == A_CTRL) && reg_wr_strb[0] && reg_wr_data[CTRL_FLUSH];
    assign sts_clear = wr_hit && (wr_word == A_STATUS) && reg_wr_strb[0] && reg_wr_data[STS_OVERFLOW];

    // Edge detection stays blocked until the third flop has been reloaded
    // from the synchronized pin, so a pin held high through reset is not
    // mistaken for a rising edge.
    assign armed = (arm_cnt == 2'd3);

    // Pop only retires a real entry; an empty pop reads back zero
    assign pop     = rd_hit && (rd_word == A_SEC_HI) && !fifo_empty;
    // Events coinciding with a flush are discarded
    assign push    = event_pulse && !flush_req;
    assign ovf_set = event_pulse && fifo_full && !pop && !flush_req;

    assign head   = fifo_empty ? '0 : fifo_q;
    assign count8 = 8'(fifo_count);
    assign irq    = ctrl_irq_en && (!fifo_empty || overflow);

    // Timestamp captured in the event cycle, optionally latency-corrected
    always_comb begin
        cap = ts_entry_t'({ptp_ts_step, ptp_ts_96});
`ifdef MQNIC_PTP_EXTTS_LATENCY_COMP_EN
        if (cap.ns < 30'(SYNC_LATENCY_NS)) begin
            cap.ns  = cap.ns + 30'(NS_PER_SEC - SYNC_LATENCY_NS);
            cap.sec = cap.sec - 48'd1;
        end else begin
            cap.ns = cap.ns - 30'(SYNC_LATENCY_NS);
        end
`endif
    end

    // Two-flop synchronizer, edge-history flop and registered event pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            arm_cnt     <= 2'd0;
            event_pulse <= 1'b0;
        end else begin
            sync1 <= ext_event;
            sync2 <= sync1;
            sync3 <= sync2;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            event_pulse <= armed && ctrl_en &&
                           ((ctrl_rise && sync2 && !sync3) ||
                            (ctrl_fall && !sync2 && sync3));
        end
    end

    // Control register writes and the sticky overflow flag (set wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en     <= 1'b0;
            ctrl_rise   <= 1'b0;
            ctrl_fall   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_hit && (wr_word == A_CTRL)) begin
                if (reg_wr_strb[0]) begin
                    ctrl_en   <= reg_wr_data[CTRL_EN];
                    ctrl_rise <= reg_wr_data[CTRL_RISE];
                    ctrl_fall <= reg_wr_data[CTRL_FALL];
                end
                if (reg_wr_strb[1]) begin
                    ctrl_irq_en <= reg_wr_data[CTRL_IRQ_EN];
                end
            end
            if (sts_clear) begin
                overflow <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read data selection for the addressed register
    always_comb begin
        rd_mux = '0;
        case (rd_word)
            A_TYPE:   rd_mux = RB_TYPE;
            A_VER:    rd_mux = RB_VERSION;
            A_NEXT:   rd_mux = 32'(RB_NEXT_PTR);
            A_CTRL:   rd_mux = {23'b0, ctrl_irq_en, 4'b0, 1'b0, ctrl_fall, ctrl_rise, ctrl_en};
            A_STATUS: rd_mux = {16'b0, count8, 5'b0, head.step, overflow, !fifo_empty};
            A_FNS:    rd_mux = {16'b0, head.fns};
            A_NS:     rd_mux = {2'b0, head.ns};
            A_SEC_LO: rd_mux = head.sec[31:0];
            A_SEC_HI: rd_mux = head.sec[47:16];
            default:  rd_mux = '0;
        endcase
    end

    // Register acknowledge and registered read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_ack  <= 1'b0;
            reg_rd_ack  <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            reg_wr_ack  <= wr_hit;
            reg_rd_ack  <= rd_hit;
            reg_rd_data <= rd_hit ? REG_DATA_WIDTH'(rd_mux) : '0;
        end
    end

    mqnic_ptp_extts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush_req),
        .wr_en   (push),
        .wr_data (cap),
        .rd_en   (pop),
        .rd_data (fifo_q),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    logic unused_bits;
    assign unused_bits = ^{reg_wr_data, reg_wr_strb, wr_off[1:0], rd_off[1:0], head.rsvd};

endmodule

// File: tb/tb_mqnic_ptp_extts.sv
// Testbench for mqnic_ptp_extts: table of timestamp vectors (fixed corner
// values plus random ones) checked against a plain-arithmetic model, and
// hand-written sequences for latency, overflow, coincident pop/flush,
// disable and reset-with-pin-high behaviour.
module tb_mqnic_ptp_extts;

    localparam int AW  = 6;
    localparam int LAT = 8;

    localparam logic [AW-1:0] A_TYPE   = 6'h00;
    localparam logic [AW-1:0] A_VER    = 6'h04;
    localparam logic [AW-1:0] A_NEXT   = 6'h08;
    localparam logic [AW-1:0] A_CTRL   = 6'h0C;
    localparam logic [AW-1:0] A_STATUS = 6'h10;
    localparam logic [AW-1:0] A_FNS    = 6'h14;
    localparam logic [AW-1:0] A_NS     = 6'h18;
    localparam logic [AW-1:0] A_SEC_LO = 6'h1C;
    localparam logic [AW-1:0] A_SEC_HI = 6'h20;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] reg_wr_addr = '0;
    logic [31:0]   reg_wr_data = '0;
    logic [3:0]    reg_wr_strb = '0;
    logic          reg_wr_en = 1'b0;
    logic          reg_wr_wait;
    logic          reg_wr_ack;
    logic [AW-1:0] reg_rd_addr = '0;
    logic          reg_rd_en = 1'b0;
    logic [31:0]   reg_rd_data;
    logic          reg_rd_wait;
    logic          reg_rd_ack;
    logic [95:0]   ptp_ts_96 = '0;
    logic          ptp_ts_step = 1'b0;
    logic          ext_event = 1'b0;
    logic          irq;

    always #5 clk = ~clk;

    mqnic_ptp_extts dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_strb (reg_wr_strb),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_wait (reg_wr_wait),
        .reg_wr_ack  (reg_wr_ack),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .reg_rd_wait (reg_rd_wait),
        .reg_rd_ack  (reg_rd_ack),
        .ptp_ts_96   (ptp_ts_96),
        .ptp_ts_step (ptp_ts_step),
        .ext_event   (ext_event),
        .irq         (irq)
    );

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [96:0]  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: what one captured entry should hold, {step, sec, 2'b0, ns, fns}
    function automatic logic [96:0] model_entry(input logic [47:0] sec, input int unsigned ns,
                                                input logic [15:0] fns, input logic step);
        logic [47:0] s;
        longint      n;
        logic [29:0] n30;
        s = sec;
        n = ns;
`ifdef MQNIC_PTP_EXTTS_LATENCY_COMP_EN
        if (n < LAT) begin
            n = n + 1000000000 - LAT;
            s = s - 48'd1;
        end else begin
            n = n - LAT;
        end
`endif
        n30 = 30'(n);
        return {step, s, 2'b00, n30, fns};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_tod(input logic [47:0] sec, input int unsigned ns,
                           input logic [15:0] fns, input logic step);
        logic [29:0] n30;
        n30 = 30'(ns);
        ptp_ts_96   = {sec, 2'b00, n30, fns};
        ptp_ts_step = step;
    endtask

    task automatic reg_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic exp_ack);
        reg_wr_addr = addr;
        reg_wr_data = data;
        reg_wr_strb = 4'hF;
        reg_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
        check("wr_ack", {31'b0, reg_wr_ack}, {31'b0, exp_ack});
    endtask

    task automatic reg_read(input logic [AW-1:0] addr, input logic exp_ack, output logic [31:0] d);
        reg_rd_addr = addr;
        reg_rd_en   = 1'b1;
        @(posedge clk);
        #1;
        reg_rd_en = 1'b0;
        check("rd_ack", {31'b0, reg_rd_ack}, {31'b0, exp_ack});
        d = reg_rd_data;
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(addr, 1'b1, d);
        check(name, d, exp);
    endtask

    // Reads the whole head entry (the last read pops) against the model queue
    task automatic check_head(input string tag);
        logic [96:0] e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        read_check({tag, "_fns"},    A_FNS,    {16'h0, e[15:0]});
        read_check({tag, "_ns"},     A_NS,     {2'b00, e[45:16]});
        read_check({tag, "_sec_lo"}, A_SEC_LO, e[79:48]);
        read_check({tag, "_sec_hi"}, A_SEC_HI, e[95:64]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [47:0] sec;
        int unsigned ns;
        logic [15:0] fns;
        logic        step;
        logic [96:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [47:0] rsec;

        // Fixed corner vectors, then random ones
        vecs[0] = '{48'd5, 100, 16'h1234, 1'b0, '0};
        vecs[1] = '{48'd10, 3, 16'h0000, 1'b0, '0};
        vecs[2] = '{48'd7, LAT, 16'hFFFF, 1'b1, '0};
        vecs[3] = '{48'd3, 0, 16'h0001, 1'b1, '0};
        vecs[4] = '{48'd2, 999999999, 16'h8000, 1'b0, '0};
        vecs[5] = '{48'hFFFF_FFFF_FFFF, 500, 16'h0007, 1'b0, '0};
        for (int i = 6; i < NV; i++) begin
            rsec = {16'($urandom), 32'($urandom)};
            if (rsec == '0) rsec = 48'd1;
            vecs[i].sec  = rsec;
            vecs[i].ns   = $urandom_range(0, 999999999);
            vecs[i].fns  = 16'($urandom);
            vecs[i].step = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < NV; i++) begin
            vecs[i].exp = model_entry(vecs[i].sec, vecs[i].ns, vecs[i].fns, vecs[i].step);
        end

        // ---- reset state ----
        tick(3);
        check("rst_wr_ack", {31'b0, reg_wr_ack}, 32'd0);
        check("rst_rd_ack", {31'b0, reg_rd_ack}, 32'd0);
        check("rst_rd_data", reg_rd_data, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("waits", {30'b0, reg_wr_wait, reg_rd_wait}, 32'd0);
        rst_n = 1'b1;
        tick(4);
        read_check("type", A_TYPE, 32'h0000C085);
        read_check("version", A_VER, 32'h00000100);
        read_check("next_ptr", A_NEXT, 32'h0);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0);

        // ---- single rising event, 4-cycle pin-to-entry latency ----
        reg_write(A_CTRL, 32'h3, 1'b1);
        set_tod(48'd5, 100, 16'h0, 1'b0);
        exp_q.push_back(model_entry(48'd5, 100, 16'h0, 1'b0));
        ext_event = 1'b1;
        tick(3);
        read_check("lat_not_yet", A_STATUS, 32'h0000);
        read_check("lat_status", A_STATUS, 32'h0101);
        check_head("first");
        read_check("first_empty", A_STATUS, 32'h0000);

        // ---- table-driven vectors, both edges enabled ----
        reg_write(A_CTRL, 32'h7, 1'b1);
        for (int i = 0; i < NV; i++) begin
            set_tod(vecs[i].sec, vecs[i].ns, vecs[i].fns, vecs[i].step);
            ext_event = ~ext_event;
            tick(6);
            read_check($sformatf("v%0d_status", i), A_STATUS, {29'b0, vecs[i].step, 2'b01} | 32'h0100);
            read_check($sformatf("v%0d_fns", i), A_FNS, {16'h0, vecs[i].exp[15:0]});
            read_check($sformatf("v%0d_ns", i), A_NS, {2'b00, vecs[i].exp[45:16]});
            read_check($sformatf("v%0d_sec_lo", i), A_SEC_LO, vecs[i].exp[79:48]);
            read_check($sformatf("v%0d_sec_hi", i), A_SEC_HI, vecs[i].exp[95:64]);
            read_check($sformatf("v%0d_empty", i), A_STATUS, 32'h0);
        end

        // ---- overflow: 9 events into depth 8, irq enabled ----
        reg_write(A_CTRL, 32'h107, 1'b1);
        for (int i = 0; i < 9; i++) begin
            set_tod(48'(100 + i), 1000 * i + 50, 16'(i), 1'b0);
            if (i < 8) exp_q.push_back(model_entry(48'(100 + i), 1000 * i + 50, 16'(i), 1'b0));
            ext_event = ~ext_event;
            tick(4);
        end
        tick(2);
        read_check("ovf_status", A_STATUS, 32'h0803);
        check("ovf_irq", {31'b0, irq}, 32'd1);
        reg_write(A_STATUS, 32'h2, 1'b1);
        read_check("w1c_status", A_STATUS, 32'h0801);
        check("w1c_irq", {31'b0, irq}, 32'd1);

        // ---- full FIFO, event coincident with a popping read ----
        set_tod(48'd200, 777, 16'd9, 1'b0);
        ext_event = ~ext_event;
        tick(3);
        begin
            logic [96:0] e;
            e = exp_q.pop_front();
            read_check("full_pop_sec_hi", A_SEC_HI, e[95:64]);
        end
        exp_q.push_back(model_entry(48'd200, 777, 16'd9, 1'b0));
        read_check("full_pop_status", A_STATUS, 32'h0801);
        check_head("after_pop_a");
        check_head("after_pop_b");
        read_check("six_left", A_STATUS, 32'h0601);

        // ---- flush with pending entries and a same-cycle event ----
        set_tod(48'd300, 5000, 16'd1, 1'b1);
        ext_event = ~ext_event;
        tick(3);
        reg_write(A_CTRL, 32'h10F, 1'b1);
        exp_q.delete();
        read_check("flush_status", A_STATUS, 32'h0000);
        read_check("flush_ctrl", A_CTRL, 32'h107);
        check("flush_irq", {31'b0, irq}, 32'd0);
        tick(4);
        read_check("flush_later", A_STATUS, 32'h0000);

        // ---- pop on empty ----
        read_check("empty_pop", A_SEC_HI, 32'h0);
        read_check("empty_pop_status", A_STATUS, 32'h0000);

        // ---- disable keeps contents and stops capture ----
        set_tod(48'd400, 1234, 16'd5, 1'b1);
        exp_q.push_back(model_entry(48'd400, 1234, 16'd5, 1'b1));
        ext_event = ~ext_event;
        tick(6);
        check("one_entry_irq", {31'b0, irq}, 32'd1);
        reg_write(A_CTRL, 32'h0, 1'b1);
        set_tod(48'd401, 4321, 16'd6, 1'b0);
        ext_event = ~ext_event;
        tick(6);
        read_check("disabled_status", A_STATUS, 32'h0105);
        check_head("retained");
        read_check("retained_empty", A_STATUS, 32'h0000);

        // ---- out-of-range access is not acknowledged ----
        reg_read(6'h24, 1'b0, d);
        check("oor_data", d, 32'h0);
        reg_write(6'h28, 32'h7, 1'b0);
        read_check("oor_no_effect", A_CTRL, 32'h0);

        // ---- reset asserted asynchronously while pin high ----
        reg_read(A_TYPE, 1'b1, d);
        ext_event = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rd_ack", {31'b0, reg_rd_ack}, 32'd0);
        check("async_rd_data", reg_rd_data, 32'h0);
        tick(3);
        rst_n = 1'b1;
        reg_write(A_CTRL, 32'h3, 1'b1);
        tick(10);
        read_check("no_spurious", A_STATUS, 32'h0000);

        // A genuine rising edge after reset is still captured
        ext_event = 1'b0;
        tick(5);
        set_tod(48'd77, 88, 16'd99, 1'b0);
        exp_q.push_back(model_entry(48'd77, 88, 16'd99, 1'b0));
        ext_event = 1'b1;
        tick(6);
        read_check("post_reset_status", A_STATUS, 32'h0101);
        check_head("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mqnic_ptp_extts.md
MQNIC_PTP_EXTTS -- requirements
Module: mqnic_ptp_extts

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, timestamp FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter SYNC_LATENCY_NS, default 8, input path latency in ns removed when compensation is compiled in.
REQ-003 SHALL have parameters REG_ADDR_WIDTH (default 6), REG_DATA_WIDTH (default 32), REG_STRB_WIDTH (default 4), RB_BASE_ADDR (default 0), RB_NEXT_PTR (default 0).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset, with ports in this order:
- clk  input  1  sole clock; all logic in this domain
- rst_n  input  1  asynchronous active-low reset
- reg_wr_addr/reg_wr_data/reg_wr_strb/reg_wr_en  input  REG_ADDR_WIDTH/32/4/1  register write
- reg_wr_wait/reg_wr_ack  output  1/1  write handshake
- reg_rd_addr/reg_rd_en  input  REG_ADDR_WIDTH/1  register read
- reg_rd_data/reg_rd_wait/reg_rd_ack  output  32/1/1  read return
- ptp_ts_96  input  96  ToD: [95:48] seconds, [45:16] ns, [15:0] fractional ns
- ptp_ts_step  input  1  ToD step indication
- ext_event  input  1  asynchronous external event pin
- irq  output  1  level interrupt

Function
REQ-005 SHALL synchronize ext_event through 2 flops, then detect edges against a third flop; an event is the first cycle after the third flop with rising (ctrl[1]) or falling (ctrl[2]) edge, qualified by ctrl[0] enable.
REQ-006 SHALL capture ptp_ts_96 and ptp_ts_step in the event cycle into the FIFO; latency from pin to entry visible: 4 clk cycles.
REQ-007 Register map (offset from RB_BASE_ADDR): 0x00 type 32'h0000C085; 0x04 version 32'h00000100; 0x08 RB_NEXT_PTR; 0x0C ctrl (bit0 en, bit1 rise, bit2 fall, bit3 flush W1S self-clearing, bit8 irq_en); 0x10 status (bit0 not-empty, bit1 overflow W1C, bit2 head step flag, [15:8] count) RO except bit1; 0x14 head fns; 0x18 head ns; 0x1C head sec[31:0]; 0x20 head sec[47:16]; reading 0x20 pops.
REQ-008 Read/write ack SHALL assert exactly 1 cycle after en, only for addresses in this block's range; wait SHALL be 0; unacked reads return data 0.
REQ-009 Full FIFO with an event and no pop: event dropped, overflow set sticky; event and pop in the same cycle while full: both accepted, no overflow.
REQ-010 Pop on empty SHALL return 0 and not change count.
REQ-011 Flush SHALL empty the FIFO in 1 cycle; an event in the flush cycle is discarded.
REQ-012 irq = irq_en & (not-empty | overflow).
REQ-013 Disabling (ctrl[0]=0) SHALL stop capture and retain FIFO contents.

Reset
REQ-014 On rst_n low, asynchronously: FIFO empty, ctrl=0, overflow=0, sync flops=0, irq=0, reg_wr_ack=0, reg_rd_ack=0, reg_rd_data=0; deassertion mid-event SHALL produce no spurious event (third flop reloaded before edge detect is enabled one cycle after release).

Configuration
REQ-015 Macro MQNIC_PTP_EXTTS_LATENCY_COMP_EN defined: captured ns SHALL be reduced by SYNC_LATENCY_NS, borrowing 1 s and adding 1,000,000,000 when ns < SYNC_LATENCY_NS; undefined: raw ptp_ts_96 stored, no subtractor.

Structure
REQ-016 Shared package SHALL hold register offsets, RB type/version constants, ctrl/status bit indices and NS_PER_SEC.
REQ-017 Sub-module mqnic_ptp_extts_fifo (synchronous FIFO, 97-bit entries, count output) SHALL be used.

Verification
REQ-018 ctrl=0x3, ToD sec=5 ns=100, rising pin -> 4 cycles later status=0x0101, 0x18 reads 100 (92 with comp).
REQ-019 ns=3, comp enabled, sec=10 -> stored sec=9, ns=999,999,995.
REQ-020 9 events into depth 8 -> count 8, overflow=1, irq=1 with irq_en; W1C 0x10 bit1 clears it.
REQ-021 Full FIFO, event coincident with 0x20 read -> count stays 8, overflow 0.
REQ-022 Flush with pending entries and a same-cycle event -> count 0, status 0x0000.
REQ-023 rst_n low during pin high, release with pin high -> no entry captured.
